csr_file: RTL and testbench
===========================

# csr_file

Control/status register file for the LoongArch pipeline core. It is the consumer of the writeback stage's exception/ERTN report and of CSR-instruction read/write requests. It updates CRMD/PRMD/ESTAT/ERA on traps and returns, and supplies the exception entry and return PC to the fetch redirect logic. It also raises the pending-interrupt indication and, optionally, runs the architectural timer.

## Interface
Parameters:
- none; all widths fixed by the ISA.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- csr_re  in  1  read strobe (for tracing only; read is combinational regardless)
- csr_num  in  14  CSR address for read and write
- csr_rvalue  out  32  read data for csr_num; 0 for unimplemented addresses
- csr_we  in  1  write enable (already gated by WB valid)
- csr_wmask  in  32  per-bit write mask
- csr_wvalue  in  32  write data
- wb_ex_valid  in  1  exception commits this cycle
- wb_ex_pc  in  32  PC of excepting instruction
- wb_ecode  in  6  exception code
- wb_esubcode  in  9  exception subcode
- wb_is_ertn  in  1  ERTN commits this cycle
- hw_int_in  in  8  hardware interrupt lines, level
- ipi_int_in  in  1  inter-processor interrupt, level
- ex_entry  out  32  EENTRY value, redirect target on exception
- ertn_pc  out  32  ERA value, redirect target on ERTN
- has_int  out  1  enabled interrupt pending

## Operation
- Implemented CSRs and their addresses:
  - CRMD 0x0: PLV[1:0], IE[2], DA[3]
  - PRMD 0x1: PPLV[1:0], PIE[2]
  - ECFG 0x4: LIE[12:0], with bit 10 reserved as 0
  - ESTAT 0x5: IS[12:0], Ecode[21:16], EsubCode[30:22]
  - ERA 0x6
  - EENTRY 0xC: VA[31:6], low bits 0
  - SAVE0–3 0x30–0x33
  - TID 0x40
  - TCFG 0x41, TVAL 0x42, TICLR 0x44 (timer build only)
- Software write: new = (old & ~wmask) | (wvalue & wmask), applied only to writable fields.
  - Read-only fields and reserved bits are unaffected.
  - Within ESTAT, only IS[1:0] is writable.
- Exception (wb_ex_valid=1):
  - PRMD.PPLV←CRMD.PLV, PRMD.PIE←CRMD.IE
  - CRMD.PLV←0, CRMD.IE←0
  - ESTAT.Ecode←wb_ecode, ESTAT.EsubCode←wb_esubcode
  - ERA←wb_ex_pc
- ERTN (wb_is_ertn=1): CRMD.PLV←PRMD.PPLV, CRMD.IE←PRMD.PIE.
- Priority when events coincide: exception > ERTN > csr_we.
  - csr_we is ignored in any cycle where wb_ex_valid or wb_is_ertn is high.
  - If wb_ex_valid and wb_is_ertn are both high, only the exception is applied.
- Interrupt inputs: ESTAT.IS[9:2]←hw_int_in and IS[12]←ipi_int_in every cycle, registered.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registers.
- ex_entry = EENTRY and ertn_pc = ERA, both combinational.

## Timing
- Reset values while resetn is low:
  - CRMD=0x00000008
  - all other CSRs=0
  - csr_rvalue=0 for csr_num 0x0 reads 0x8
  - ex_entry=0, ertn_pc=0, has_int=0
- Read is combinational, with zero latency. A write in cycle N is visible on csr_rvalue in cycle N+1 (no bypass).
- Exception/ERTN updates land at the edge ending the commit cycle.
  - ex_entry is stable during the commit cycle.
  - ertn_pc reflects ERA from before any same-cycle update.
- Interrupt lines reach has_int one cycle after they change. has_int is 0 whenever CRMD.IE=0.
- Reset asserted mid-operation clears all state immediately, including the timer.

## Configuration
- CSR_TIMER_EN defined: TID/TCFG/TVAL/TICLR are implemented.
  - TCFG fields: En[0], Periodic[1], InitVal[31:2].
  - A TCFG write loads TVAL←{InitVal,2'b00} (written values) at that edge.
  - Each following cycle with En=1 and TVAL≠0, TVAL decrements by 1.
  - When TVAL goes 1→0, ESTAT.IS[11]←1. If Periodic=1, TVAL reloads to {InitVal,2'b00} on the next edge; otherwise TVAL holds at 0.
  - Writing TICLR with bit0=1 clears IS[11]. TICLR always reads 0. TVAL is read-only.
  - If a TICLR clear coincides with a timer expiry, the expiry wins.
- CSR_TIMER_EN undefined: addresses 0x40–0x44 read 0 and ignore writes, and IS[11] is constant 0.

## Test plan
- Reset, then read CRMD, ESTAT and ERA → values 0x8, 0, 0; has_int=0.
- Write ERA with wmask=0x0000FFFF and wvalue=0x12345678, old value 0xAAAAAAAA → next-cycle read returns 0xAAAA5678.
- With CRMD=0x7 (PLV=3, IE=1), pulse wb_ex_valid with ecode=0x0B and pc=0x1C000100 → CRMD=0x0, PRMD=0x7, ESTAT[21:16]=0x0B, ERA=0x1C000100. Then pulse wb_is_ertn → CRMD=0x7 and ertn_pc=0x1C000100.
- Assert wb_ex_valid together with csr_we targeting SAVE0 → SAVE0 is unchanged and exception state is updated.
- ECFG.LIE=0x4, CRMD.IE=1, hw_int_in[0]=1 → has_int=1 one cycle later. Clear IE → has_int=0.
- Timer build: TCFG=0x0000000D (InitVal=3, i.e. 12 cycles, periodic off, En=1) → TVAL counts 12→0, IS[11] sets at zero, has_int follows when LIE[11]=1. TICLR=1 clears IS[11].

Source files
------------

// File: rtl/csr_file.sv
// csr_file: LoongArch CRMD/PRMD/ECFG/ESTAT/ERA/EENTRY/SAVE CSRs with trap entry, ERTN and interrupt pending.
// Define CSR_TIMER_EN to add TID/TCFG/TVAL/TICLR and the timer interrupt on ESTAT.IS[11].
module csr_file (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex_valid,
    input  logic [31:0] wb_ex_pc,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic        wb_is_ertn,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_pc,
    output logic        has_int
);
    localparam logic [13:0] ADDR_CRMD   = 14'h000;
    localparam logic [13:0] ADDR_PRMD   = 14'h001;
    localparam logic [13:0] ADDR_ECFG   = 14'h004;
    localparam logic [13:0] ADDR_ESTAT  = 14'h005;
    localparam logic [13:0] ADDR_ERA    = 14'h006;
    localparam logic [13:0] ADDR_EENTRY = 14'h00C;
    localparam logic [13:0] ADDR_SAVE0  = 14'h030;
    localparam logic [13:0] ADDR_SAVE1  = 14'h031;
    localparam logic [13:0] ADDR_SAVE2  = 14'h032;
    localparam logic [13:0] ADDR_SAVE3  = 14'h033;
`ifdef CSR_TIMER_EN
    localparam logic [13:0] ADDR_TID    = 14'h040;
    localparam logic [13:0] ADDR_TCFG   = 14'h041;
    localparam logic [13:0] ADDR_TVAL   = 14'h042;
    localparam logic [13:0] ADDR_TICLR  = 14'h044;
`endif
    localparam logic [12:0] LIE_MASK    = 13'h1BFF;

    logic [3:0]       crmd_q, crmd_d;
    logic [2:0]       prmd_q, prmd_d;
    logic [12:0]      ecfg_q, ecfg_d;
    logic [12:0]      estat_is_q, estat_is_d;
    logic [5:0]       estat_ecode_q, estat_ecode_d;
    logic [8:0]       estat_esub_q, estat_esub_d;
    logic [31:0]      era_q, era_d;
    logic [25:0]      eentry_q, eentry_d;
    logic [3:0][31:0] save_q, save_d;
`ifdef CSR_TIMER_EN
    logic [31:0]      tid_q, tid_d;
    logic [31:0]      tcfg_q, tcfg_d;
    logic [31:0]      tval_q, tval_d;
    logic             timer_fire;
`endif

    logic        sw_we;
    logic [31:0] merged;
    logic        unused_csr_re;

    assign unused_csr_re = csr_re;

    always_comb begin
        csr_rvalue = '0;
        case (csr_num)
            ADDR_CRMD:   csr_rvalue = {28'b0, crmd_q};
            ADDR_PRMD:   csr_rvalue = {29'b0, prmd_q};
            ADDR_ECFG:   csr_rvalue = {19'b0, ecfg_q};
            ADDR_ESTAT:  csr_rvalue = {1'b0, estat_esub_q, estat_ecode_q, 3'b0, estat_is_q};
            ADDR_ERA:    csr_rvalue = era_q;
            ADDR_EENTRY: csr_rvalue = {eentry_q, 6'b0};
            ADDR_SAVE0, ADDR_SAVE1, ADDR_SAVE2, ADDR_SAVE3:
                         csr_rvalue = save_q[csr_num[1:0]];
`ifdef CSR_TIMER_EN
            ADDR_TID:    csr_rvalue = tid_q;
            ADDR_TCFG:   csr_rvalue = tcfg_q;
            ADDR_TVAL:   csr_rvalue = tval_q;
`endif
            default:     csr_rvalue = '0;
        endcase
    end

    // The merge uses the read path as "old", so unreadable bits merge from 0.
    assign merged = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);
    assign sw_we  = csr_we & ~wb_ex_valid & ~wb_is_ertn;

    always_comb begin
        crmd_d        = crmd_q;
        prmd_d        = prmd_q;
        ecfg_d        = ecfg_q;
        estat_is_d    = estat_is_q;
        estat_ecode_d = estat_ecode_q;
        estat_esub_d  = estat_esub_q;
        era_d         = era_q;
        eentry_d      = eentry_q;
        save_d        = save_q;
`ifdef CSR_TIMER_EN
        tid_d         = tid_q;
        tcfg_d        = tcfg_q;
        tval_d        = tval_q;
        timer_fire    = 1'b0;
`endif
        estat_is_d[9:2] = hw_int_in;
        estat_is_d[10]  = 1'b0;
        estat_is_d[12]  = ipi_int_in;

        if (wb_ex_valid) begin
            prmd_d        = crmd_q[2:0];
            crmd_d        = {crmd_q[3], 3'b000};
            estat_ecode_d = wb_ecode;
            estat_esub_d  = wb_esubcode;
            era_d         = wb_ex_pc;
        end else if (wb_is_ertn) begin
            crmd_d = {crmd_q[3], prmd_q};
        end else if (csr_we) begin
            case (csr_num)
                ADDR_CRMD:   crmd_d = merged[3:0];
                ADDR_PRMD:   prmd_d = merged[2:0];
                ADDR_ECFG:   ecfg_d = merged[12:0] & LIE_MASK;
                ADDR_ESTAT:  estat_is_d[1:0] = merged[1:0];
                ADDR_ERA:    era_d = merged;
                ADDR_EENTRY: eentry_d = merged[31:6];
                ADDR_SAVE0, ADDR_SAVE1, ADDR_SAVE2, ADDR_SAVE3:
                             save_d[csr_num[1:0]] = merged;
`ifdef CSR_TIMER_EN
                ADDR_TID:    tid_d = merged;
                ADDR_TCFG:   tcfg_d = merged;
`endif
                default: ;
            endcase
        end

`ifdef CSR_TIMER_EN
        if (sw_we && csr_num == ADDR_TCFG) begin
            tval_d = {merged[31:2], 2'b00};
        end else if (tcfg_q[0] && tval_q != 32'd0) begin
            tval_d     = tval_q - 32'd1;
            timer_fire = (tval_q == 32'd1);
        end else if (tcfg_q[0] && tcfg_q[1]) begin
            tval_d = {tcfg_q[31:2], 2'b00};
        end

        // Expiry beats a same-cycle TICLR clear.
        if (timer_fire)
            estat_is_d[11] = 1'b1;
        else if (sw_we && csr_num == ADDR_TICLR && merged[0])
            estat_is_d[11] = 1'b0;
`else
        estat_is_d[11] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_q        <= 4'h8;
            prmd_q        <= '0;
            ecfg_q        <= '0;
            estat_is_q    <= '0;
            estat_ecode_q <= '0;
            estat_esub_q  <= '0;
            era_q         <= '0;
            eentry_q      <= '0;
            save_q        <= '0;
`ifdef CSR_TIMER_EN
            tid_q         <= '0;
            tcfg_q        <= '0;
            tval_q        <= '0;
`endif
        end else begin
            crmd_q        <= crmd_d;
            prmd_q        <= prmd_d;
            ecfg_q        <= ecfg_d;
            estat_is_q    <= estat_is_d;
            estat_ecode_q <= estat_ecode_d;
            estat_esub_q  <= estat_esub_d;
            era_q         <= era_d;
            eentry_q      <= eentry_d;
            save_q        <= save_d;
`ifdef CSR_TIMER_EN
            tid_q         <= tid_d;
            tcfg_q        <= tcfg_d;
            tval_q        <= tval_d;
`endif
        end
    end

    assign ex_entry = {eentry_q, 6'b0};
    assign ertn_pc  = era_q;
    assign has_int  = crmd_q[2] & |(estat_is_q & ecfg_q);

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: vector table for plain CSR access, hand sequences for traps, interrupts and timer.
// Timer checks are compiled when CSR_TIMER_EN is defined, otherwise the timer addresses are checked as absent.
module tb_csr_file;
    logic        clk = 1'b0;
    logic        resetn;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex_valid;
    logic [31:0] wb_ex_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        wb_is_ertn;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_pc;
    logic        has_int;

    localparam logic [13:0] A_CRMD = 14'h0, A_PRMD = 14'h1, A_ECFG = 14'h4, A_ESTAT = 14'h5;
    localparam logic [13:0] A_ERA = 14'h6, A_EENTRY = 14'hC;
    localparam logic [13:0] A_SAVE0 = 14'h30, A_SAVE1 = 14'h31, A_SAVE2 = 14'h32, A_SAVE3 = 14'h33;
    localparam logic [13:0] A_TID = 14'h40, A_TCFG = 14'h41, A_TVAL = 14'h42, A_TICLR = 14'h44;

    always #5 clk = ~clk;

    csr_file dut (
        .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num),
        .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .wb_ex_valid(wb_ex_valid), .wb_ex_pc(wb_ex_pc),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_is_ertn(wb_is_ertn),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .ex_entry(ex_entry),
        .ertn_pc(ertn_pc), .has_int(has_int)
    );

    typedef struct {
        logic        is_wr;
        logic [13:0] num;
        logic [31:0] mask;
        logic [31:0] val;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        csr_num = num; csr_wmask = mask; csr_wvalue = val; csr_we = 1'b1; csr_re = 1'b0;
        tick();
        csr_we = 1'b0;
    endtask

    // Expected value is queued as the read is issued and retired once the read path settles.
    task automatic rd(input string name, input logic [13:0] num, input logic [31:0] exp);
        csr_num = num; csr_re = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        #1;
        check(name_q.pop_front(), csr_rvalue, exp_q.pop_front());
        csr_re = 1'b0;
    endtask

    task automatic rd_bit(input string name, input logic [13:0] num, input int b, input logic exp);
        csr_num = num;
        #1;
        check(name, {31'b0, csr_rvalue[b]}, {31'b0, exp});
    endtask

    function automatic void add(input logic w, input logic [13:0] n, input logic [31:0] m,
                                input logic [31:0] v, input logic [31:0] e);
        vec_t t;
        t.is_wr = w; t.num = n; t.mask = m; t.val = v; t.exp = e;
        vecs.push_back(t);
    endfunction

    initial begin
        resetn = 1'b0; csr_re = 1'b0; csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
        wb_ex_valid = 1'b0; wb_ex_pc = '0; wb_ecode = '0; wb_esubcode = '0; wb_is_ertn = 1'b0;
        hw_int_in = '0; ipi_int_in = 1'b0;

        add(1, A_ERA,    32'hFFFFFFFF, 32'hAAAAAAAA, 0);
        add(1, A_ERA,    32'h0000FFFF, 32'h12345678, 0);
        add(0, A_ERA,    0, 0, 32'hAAAA5678);
        add(1, A_EENTRY, 32'hFFFFFFFF, 32'h1C0000FF, 0);
        add(0, A_EENTRY, 0, 0, 32'h1C0000C0);
        add(1, A_ECFG,   32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        add(0, A_ECFG,   0, 0, 32'h00001BFF);
        add(1, A_ECFG,   32'hFFFFFFFF, 32'h00000000, 0);
        add(1, A_ESTAT,  32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        add(0, A_ESTAT,  0, 0, 32'h00000003);
        add(1, A_ESTAT,  32'h00000003, 32'h00000000, 0);
        add(0, A_ESTAT,  0, 0, 32'h00000000);
        add(1, A_CRMD,   32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        add(0, A_CRMD,   0, 0, 32'h0000000F);
        add(1, A_CRMD,   32'h0000000F, 32'h00000007, 0);
        add(0, A_CRMD,   0, 0, 32'h00000007);
        add(1, A_PRMD,   32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        add(0, A_PRMD,   0, 0, 32'h00000007);
        add(1, A_PRMD,   32'hFFFFFFFF, 32'h00000000, 0);
        add(0, A_PRMD,   0, 0, 32'h00000000);
        add(1, A_SAVE0,  32'hFFFFFFFF, 32'h11111111, 0);
        add(1, A_SAVE1,  32'hFFFFFFFF, 32'h22222222, 0);
        add(1, A_SAVE2,  32'hFFFFFFFF, 32'h33333333, 0);
        add(1, A_SAVE3,  32'hFF00FF00, 32'h44444444, 0);
        add(0, A_SAVE0,  0, 0, 32'h11111111);
        add(0, A_SAVE1,  0, 0, 32'h22222222);
        add(0, A_SAVE2,  0, 0, 32'h33333333);
        add(0, A_SAVE3,  0, 0, 32'h44004400);
        add(1, 14'h007,  32'hFFFFFFFF, 32'hCAFEF00D, 0);
        add(0, 14'h007,  0, 0, 32'h00000000);

        #12;
        rd("rst_crmd", A_CRMD, 32'h8);
        rd("rst_estat", A_ESTAT, 32'h0);
        rd("rst_era", A_ERA, 32'h0);
        rd("rst_save0", A_SAVE0, 32'h0);
        check("rst_ex_entry", ex_entry, 32'h0);
        check("rst_ertn_pc", ertn_pc, 32'h0);
        check("rst_has_int", {31'b0, has_int}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) wr(vecs[i].num, vecs[i].mask, vecs[i].val);
            else rd($sformatf("vec%0d", i), vecs[i].num, vecs[i].exp);
        end

        // Exception with a colliding SAVE0 write.
        csr_num = A_SAVE0; csr_wmask = 32'hFFFFFFFF; csr_wvalue = 32'hDEADBEEF; csr_we = 1'b1;
        wb_ex_valid = 1'b1; wb_ex_pc = 32'h1C000100; wb_ecode = 6'h0B; wb_esubcode = 9'h0;
        #1;
        check("ex_entry_commit", ex_entry, 32'h1C0000C0);
        check("ertn_pc_pre_ex", ertn_pc, 32'hAAAA5678);
        tick();
        csr_we = 1'b0; wb_ex_valid = 1'b0;
        rd("ex_crmd", A_CRMD, 32'h0);
        rd("ex_prmd", A_PRMD, 32'h7);
        rd("ex_estat", A_ESTAT, 32'h000B0000);
        rd("ex_era", A_ERA, 32'h1C000100);
        rd("ex_save0_kept", A_SAVE0, 32'h11111111);
        check("ex_ertn_pc", ertn_pc, 32'h1C000100);

        // ERTN with a colliding CRMD write.
        csr_num = A_CRMD; csr_wmask = 32'hF; csr_wvalue = 32'h0; csr_we = 1'b1; wb_is_ertn = 1'b1;
        tick();
        csr_we = 1'b0; wb_is_ertn = 1'b0;
        rd("ertn_crmd", A_CRMD, 32'h7);

        // Exception and ERTN together: exception only.
        wb_ex_valid = 1'b1; wb_is_ertn = 1'b1; wb_ex_pc = 32'h1C000200; wb_ecode = 6'h03; wb_esubcode = 9'h005;
        tick();
        wb_ex_valid = 1'b0; wb_is_ertn = 1'b0;
        rd("both_crmd", A_CRMD, 32'h0);
        rd("both_era", A_ERA, 32'h1C000200);
        rd("both_estat", A_ESTAT, 32'h01430000);
        wb_is_ertn = 1'b1;
        tick();
        wb_is_ertn = 1'b0;
        rd("both_ertn_crmd", A_CRMD, 32'h7);

        // Hardware interrupt line 0 -> IS[2].
        wr(A_ECFG, 32'hFFFFFFFF, 32'h4);
        hw_int_in = 8'h01;
        #1;
        check("hwint_before_edge", {31'b0, has_int}, 32'h0);
        tick();
        check("hwint_has_int", {31'b0, has_int}, 32'h1);
        rd("hwint_estat", A_ESTAT, 32'h01430004);
        wr(A_CRMD, 32'h4, 32'h0);
        check("hwint_ie_off", {31'b0, has_int}, 32'h0);
        hw_int_in = 8'h00;
        wr(A_ECFG, 32'hFFFFFFFF, 32'h1000);
        wr(A_CRMD, 32'h4, 32'h4);
        hw_int_in = 8'h80;
        tick();
        check("hwint_unmasked_line", {31'b0, has_int}, 32'h0);
        hw_int_in = 8'h00;
        ipi_int_in = 1'b1;
        tick();
        check("ipi_has_int", {31'b0, has_int}, 32'h1);
        ipi_int_in = 1'b0;
        tick();
        check("ipi_drop", {31'b0, has_int}, 32'h0);

`ifdef CSR_TIMER_EN
        wr(A_TID, 32'hFFFFFFFF, 32'h00005A5A);
        rd("tid", A_TID, 32'h00005A5A);
        wr(A_ECFG, 32'hFFFFFFFF, 32'h800);
        wr(A_TCFG, 32'hFFFFFFFF, 32'h0000000D);
        rd("tval_load", A_TVAL, 32'd12);
        check("timer_no_int_yet", {31'b0, has_int}, 32'h0);
        for (int i = 11; i >= 0; i--) begin
            tick();
            rd($sformatf("tval_%0d", i), A_TVAL, i);
        end
        rd_bit("timer_is11_set", A_ESTAT, 11, 1'b1);
        check("timer_has_int", {31'b0, has_int}, 32'h1);
        tick();
        rd("tval_hold", A_TVAL, 32'h0);
        wr(A_TICLR, 32'hFFFFFFFF, 32'h1);
        rd_bit("ticlr_clears", A_ESTAT, 11, 1'b0);
        check("ticlr_has_int", {31'b0, has_int}, 32'h0);
        rd("ticlr_reads0", A_TICLR, 32'h0);
        wr(A_TVAL, 32'hFFFFFFFF, 32'h12345678);
        rd("tval_ro", A_TVAL, 32'h0);

        wr(A_TCFG, 32'hFFFFFFFF, 32'h00000007);
        rd("per_load", A_TVAL, 32'd4);
        for (int i = 0; i < 4; i++) tick();
        rd("per_zero", A_TVAL, 32'd0);
        rd_bit("per_fire", A_ESTAT, 11, 1'b1);
        tick();
        rd("per_reload", A_TVAL, 32'd4);
        wr(A_TICLR, 32'hFFFFFFFF, 32'h1);
        for (int i = 0; i < 2; i++) tick();
        rd("per_one", A_TVAL, 32'd1);
        rd_bit("per_cleared", A_ESTAT, 11, 1'b0);
        wr(A_TICLR, 32'hFFFFFFFF, 32'h1);
        rd("coinc_tval", A_TVAL, 32'd0);
        rd_bit("coinc_expiry_wins", A_ESTAT, 11, 1'b1);
        tick();
        rd("coinc_reload", A_TVAL, 32'd4);
`else
        wr(A_TID, 32'hFFFFFFFF, 32'h00005A5A);
        rd("notimer_tid", A_TID, 32'h0);
        wr(A_TCFG, 32'hFFFFFFFF, 32'h00000005);
        rd("notimer_tcfg", A_TCFG, 32'h0);
        wr(A_ECFG, 32'hFFFFFFFF, 32'h800);
        for (int i = 0; i < 6; i++) tick();
        rd("notimer_tval", A_TVAL, 32'h0);
        rd_bit("notimer_is11", A_ESTAT, 11, 1'b0);
        check("notimer_has_int", {31'b0, has_int}, 32'h0);
`endif

        // Asynchronous reset mid-operation.
        hw_int_in = 8'h01;
        wr(A_ECFG, 32'hFFFFFFFF, 32'h4);
        tick();
        resetn = 1'b0;
        #2;
        rd("mid_rst_crmd", A_CRMD, 32'h8);
        rd("mid_rst_save0", A_SAVE0, 32'h0);
        rd("mid_rst_ecfg", A_ECFG, 32'h0);
        check("mid_rst_ex_entry", ex_entry, 32'h0);
        check("mid_rst_has_int", {31'b0, has_int}, 32'h0);
`ifdef CSR_TIMER_EN
        rd("mid_rst_tval", A_TVAL, 32'h0);
        rd("mid_rst_tcfg", A_TCFG, 32'h0);
`endif
        hw_int_in = 8'h00;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        tick();
`ifdef CSR_TIMER_EN
        rd("post_rst_tval", A_TVAL, 32'h0);
`endif
        rd("post_rst_estat", A_ESTAT, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
